jtag_master: RTL and testbench

// - JTAG initiator that drives a downstream JTAG TAP, such as the FIR-filter configuration TAP.
// - Accepts IR-scan, DR-scan and TAP-reset commands on a valid/ready port in the iClk domain.
// - Generates oTck, oTms and oTdi, and captures oTdo from the TAP.
// - Returns captured bits on a valid/ready response port; used by the on-board test controller.

---
 rtl/jtag_pkg.sv | 63 ++++++
 rtl/jtag_tck_gen.sv | 41 ++++
 rtl/jtag_master.sv | 219 +++++++++++++++++++++
 tb/tb_jtag_master.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// jtag_pkg: shared JTAG definitions.
// Holds the TAP state encoding, the master command type codes, the
// instruction codes of the target TAPs and the standard TAP transition rule.
package jtag_pkg;

  localparam int unsigned TapW = 4;
  localparam int unsigned LenW = 6;

  typedef enum logic [TapW-1:0] {
    TestLogicReset = 4'hF,
    RunTestIdle    = 4'hC,
    SelectDr       = 4'h7,
    CaptureDr      = 4'h6,
    ShiftDr        = 4'h2,
    Exit1Dr        = 4'h1,
    PauseDr        = 4'h3,
    Exit2Dr        = 4'h0,
    UpdateDr       = 4'h5,
    SelectIr       = 4'h4,
    CaptureIr      = 4'hE,
    ShiftIr        = 4'hA,
    Exit1Ir        = 4'h9,
    PauseIr        = 4'hB,
    Exit2Ir        = 4'h8,
    UpdateIr       = 4'hD
  } tapState_e;

  typedef enum logic [1:0] {
    CmdDr    = 2'd0,
    CmdIr    = 2'd1,
    CmdReset = 2'd2,
    CmdRsvd  = 2'd3
  } cmdType_e;

  localparam logic [3:0] InstrBypass = 4'b0001;
  localparam logic [3:0] InstrIdcode = 4'b0010;
  localparam logic [3:0] InstrConfig = 4'b0100;

  // Standard IEEE 1149.1 TAP controller transition on a rising TCK.
  function automatic tapState_e tapNext(input tapState_e s, input logic tms);
    tapState_e n;
    unique case (s)
      TestLogicReset: n = tms ? TestLogicReset : RunTestIdle;
      RunTestIdle:    n = tms ? SelectDr       : RunTestIdle;
      SelectDr:       n = tms ? SelectIr       : CaptureDr;
      CaptureDr:      n = tms ? Exit1Dr        : ShiftDr;
      ShiftDr:        n = tms ? Exit1Dr        : ShiftDr;
      Exit1Dr:        n = tms ? UpdateDr       : PauseDr;
      PauseDr:        n = tms ? Exit2Dr        : PauseDr;
      Exit2Dr:        n = tms ? UpdateDr       : ShiftDr;
      UpdateDr:       n = tms ? SelectDr       : RunTestIdle;
      SelectIr:       n = tms ? TestLogicReset : CaptureIr;
      CaptureIr:      n = tms ? Exit1Ir        : ShiftIr;
      ShiftIr:        n = tms ? Exit1Ir        : ShiftIr;
      Exit1Ir:        n = tms ? UpdateIr       : PauseIr;
      PauseIr:        n = tms ? Exit2Ir        : PauseIr;
      Exit2Ir:        n = tms ? UpdateIr       : ShiftIr;
      UpdateIr:       n = tms ? SelectDr       : RunTestIdle;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: TCK divider for the JTAG master.
// Ports: iClk/iTrst clock and async active-low reset; iEn runs the divider;
// oTck divided clock (idles low once disabled); oRise_c/oFall_c are
// single-cycle strobes on the iClk cycle that drives oTck 0->1 / 1->0.
module jtag_tck_gen #(
  parameter int unsigned CLKDIV = 2
) (
  input  logic iClk,
  input  logic iTrst,
  input  logic iEn,
  output logic oTck,
  output logic oRise_c,
  output logic oFall_c
);

  localparam int unsigned CntW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  logic [CntW-1:0] cnt;
  logic            tick;

  assign tick    = iEn && (cnt == CntW'(CLKDIV - 1));
  assign oRise_c = tick & ~oTck;
  assign oFall_c = tick & oTck;

  // Half-period counter; the master keeps iEn high while oTck is high,
  // so disabling always leaves the clock low.
  always_ff @(posedge iClk or negedge iTrst) begin
    if (!iTrst) begin
      cnt  <= '0;
      oTck <= 1'b0;
    end else if (!iEn) begin
      cnt <= '0;
    end else if (tick) begin
      cnt  <= '0;
      oTck <= ~oTck;
    end else begin
      cnt <= cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/jtag_master.sv
// jtag_master: JTAG initiator driving a downstream TAP.
// Ports: iClk/iTrst clock and async active-low reset; iCmd* command
// valid/ready port (type, length, TDI data); oRsp*/iRspReady response port
// with captured TDO; oTck/oTms/oTdi/iTdo JTAG pins; oTapState tracked TAP
// state in the shared encoding.
module jtag_master
  import jtag_pkg::*;
#(
  parameter int unsigned CLKDIV = 2,
  parameter int unsigned MAXLEN = 32
) (
  input  logic              iClk,
  input  logic              iTrst,
  input  logic              iCmdValid,
  output logic              oCmdReady,
  input  logic [1:0]        iCmdType,
  input  logic [5:0]        iCmdLen,
  input  logic [MAXLEN-1:0] iCmdData,
  output logic              oRspValid,
  input  logic              iRspReady,
  output logic [MAXLEN-1:0] oRspData,
  output logic              oTck,
  output logic              oTms,
  output logic              oTdi,
  input  logic              iTdo,
  output logic [3:0]        oTapState
);

  localparam int unsigned ShW = LenW + 1;

  typedef enum logic [2:0] {StInit, StIdle, StPre, StShift, StPost, StRsp} mstState_e;

  mstState_e         state, stateNext;
  tapState_e         tapState, tapStateNext;
  logic [LenW-1:0]   stepCnt, stepCntNext;
  logic [LenW-1:0]   len, lenNext, lenIn;
  logic              isIr, isIrNext, isRst, isRstNext;
  logic [MAXLEN-1:0] dataSr, dataSrNext, cap, capNext, rspData, rspDataNext;
  logic              tms, tmsNext, tdi, tdiNext;
  logic              rspValid, rspValidNext, cmdReady, cmdReadyNext;
  logic [LenW-1:0]   preLen, preOnes;
  logic              tmsBit, tdiBit;
  logic              tckEn, rise, fall;

  jtag_tck_gen #(.CLKDIV(CLKDIV)) uTckGen (
    .iClk    (iClk),
    .iTrst   (iTrst),
    .iEn     (tckEn),
    .oTck    (oTck),
    .oRise_c (rise),
    .oFall_c (fall)
  );

  assign oCmdReady = cmdReady;
  assign oRspValid = rspValid;
  assign oRspData  = rspData;
  assign oTms      = tms;
  assign oTdi      = tdi;
  assign oTapState = tapState;

  // State and datapath registers.
  always_ff @(posedge iClk or negedge iTrst) begin
    if (!iTrst) begin
      state    <= StInit;
      tapState <= TestLogicReset;
      stepCnt  <= '0;
      len      <= '0;
      isIr     <= 1'b0;
      isRst    <= 1'b0;
      dataSr   <= '0;
      cap      <= '0;
      rspData  <= '0;
      tms      <= 1'b1;
      tdi      <= 1'b0;
      rspValid <= 1'b0;
      cmdReady <= 1'b0;
    end else begin
      state    <= stateNext;
      tapState <= tapStateNext;
      stepCnt  <= stepCntNext;
      len      <= lenNext;
      isIr     <= isIrNext;
      isRst    <= isRstNext;
      dataSr   <= dataSrNext;
      cap      <= capNext;
      rspData  <= rspDataNext;
      tms      <= tmsNext;
      tdi      <= tdiNext;
      rspValid <= rspValidNext;
      cmdReady <= cmdReadyNext;
    end
  end

  // Next-state and sequencing. stepCnt indexes the upcoming TCK of the
  // current phase; the falling edge loads its TMS/TDI, the rising edge
  // consumes it. Outside a sequence TMS parks at 1, the first value of
  // every command's walk out of RunTestIdle.
  always_comb begin
    stateNext    = state;
    tapStateNext = tapState;
    stepCntNext  = stepCnt;
    lenNext      = len;
    isIrNext     = isIr;
    isRstNext    = isRst;
    dataSrNext   = dataSr;
    capNext      = cap;
    rspDataNext  = rspData;
    tmsNext      = tms;
    tdiNext      = tdi;
    rspValidNext = rspValid;

    tckEn   = (state inside {StInit, StPre, StShift, StPost}) || oTck;
    preLen  = isRst ? LenW'(6) : (isIr ? LenW'(4) : LenW'(3));
    preOnes = isRst ? LenW'(5) : (isIr ? LenW'(2) : LenW'(1));
    lenIn   = (iCmdLen > LenW'(MAXLEN)) ? LenW'(MAXLEN) : iCmdLen;

    tmsBit = 1'b1;
    tdiBit = 1'b0;
    case (state)
      StInit:  tmsBit = (stepCnt < LenW'(5));
      StPre:   tmsBit = (stepCnt < preOnes);
      StShift: begin
        tmsBit = (stepCnt == len - LenW'(1));
        tdiBit = dataSr[0];
      end
      StPost:  tmsBit = (stepCnt == '0);
      default: ;
    endcase

    if (fall) begin
      tmsNext = tmsBit;
      tdiNext = tdiBit;
    end
    if (rise) begin
      tapStateNext = tapNext(tapState, tms);
    end

    case (state)
      StInit: begin
        if (rise) begin
          if (stepCnt == LenW'(5)) begin
            stateNext   = StIdle;
            stepCntNext = '0;
          end else begin
            stepCntNext = stepCnt + LenW'(1);
          end
        end
      end
      StIdle: begin
        if (iCmdValid && cmdReady) begin
          isRstNext   = iCmdType[1];
          isIrNext    = (iCmdType == CmdIr);
          lenNext     = lenIn;
          dataSrNext  = iCmdData;
          capNext     = '0;
          stepCntNext = '0;
          if (!iCmdType[1] && (lenIn == '0)) begin
            stateNext    = StRsp;
            rspValidNext = 1'b1;
            rspDataNext  = '0;
          end else begin
            stateNext = StPre;
          end
        end
      end
      StPre: begin
        if (rise) begin
          if (stepCnt == preLen - LenW'(1)) begin
            stepCntNext = '0;
            if (isRst) begin
              stateNext    = StRsp;
              rspValidNext = 1'b1;
              rspDataNext  = '0;
            end else begin
              stateNext = StShift;
            end
          end else begin
            stepCntNext = stepCnt + LenW'(1);
          end
        end
      end
      StShift: begin
        if (rise) begin
          // Captured bits enter at the top and are right-aligned at the end.
          capNext    = {iTdo, cap[MAXLEN-1:1]};
          dataSrNext = dataSr >> 1;
          if (stepCnt == len - LenW'(1)) begin
            stateNext   = StPost;
            stepCntNext = '0;
          end else begin
            stepCntNext = stepCnt + LenW'(1);
          end
        end
      end
      StPost: begin
        if (rise) begin
          if (stepCnt == LenW'(1)) begin
            stateNext    = StRsp;
            stepCntNext  = '0;
            rspValidNext = 1'b1;
            rspDataNext  = cap >> (ShW'(MAXLEN) - {1'b0, len});
          end else begin
            stepCntNext = stepCnt + LenW'(1);
          end
        end
      end
      StRsp: begin
        if (iRspReady) begin
          stateNext    = StIdle;
          rspValidNext = 1'b0;
        end
      end
      default: stateNext = StInit;
    endcase

    cmdReadyNext = (stateNext == StIdle) && !rspValidNext;
  end

endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: directed bench for jtag_master with a behavioural TAP
// (IDCODE 32'h149511c3, 1-bit BYPASS). Table-driven command vectors plus
// hand-written init, backpressure and abort sequences.
module tb_jtag_master;

  localparam int unsigned CLKDIV = 2;
  localparam int unsigned MAXLEN = 32;
  localparam logic [31:0] IdCode = 32'h149511c3;
  localparam logic [3:0]  IrIdcode = 4'b0010;

  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SDS = 4'h7, S_CDR = 4'h6,
                         S_SDR = 4'h2, S_E1D = 4'h1, S_PDR = 4'h3, S_E2D = 4'h0,
                         S_UDR = 4'h5, S_SIS = 4'h4, S_CIR = 4'hE, S_SIR = 4'hA,
                         S_E1I = 4'h9, S_PIR = 4'hB, S_E2I = 4'h8, S_UIR = 4'hD;

  logic        iClk = 1'b0;
  logic        iTrst = 1'b0;
  logic        iCmdValid = 1'b0;
  logic        iRspReady = 1'b0;
  logic [1:0]  iCmdType = '0;
  logic [5:0]  iCmdLen = '0;
  logic [31:0] iCmdData = '0;
  logic        iTdo;
  logic        oCmdReady, oRspValid, oTck, oTms, oTdi;
  logic [31:0] oRspData;
  logic [3:0]  oTapState;

  jtag_master #(.CLKDIV(CLKDIV), .MAXLEN(MAXLEN)) dut (
    .iClk      (iClk),
    .iTrst     (iTrst),
    .iCmdValid (iCmdValid),
    .oCmdReady (oCmdReady),
    .iCmdType  (iCmdType),
    .iCmdLen   (iCmdLen),
    .iCmdData  (iCmdData),
    .oRspValid (oRspValid),
    .iRspReady (iRspReady),
    .oRspData  (oRspData),
    .oTck      (oTck),
    .oTms      (oTms),
    .oTdi      (oTdi),
    .iTdo      (iTdo),
    .oTapState (oTapState)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc++;

  // TCK observers
  int          tckRises = 0;
  int          lastRise = 0;
  int          period = 0;
  logic [31:0] tmsHist = '0;
  always @(posedge oTck) begin
    period   = cyc - lastRise;
    lastRise = cyc;
    tckRises++;
    tmsHist  = {tmsHist[30:0], oTms};
  end

  // Behavioural target TAP
  logic [3:0]  tapSt = S_TLR;
  logic [3:0]  ir = IrIdcode;
  logic [3:0]  irsr = '0;
  logic [31:0] idsr = '0;
  logic        bp = 1'b0;

  function automatic logic [3:0] tapStep(input logic [3:0] s, input logic m);
    case (s)
      S_TLR: return m ? S_TLR : S_RTI;
      S_RTI: return m ? S_SDS : S_RTI;
      S_SDS: return m ? S_SIS : S_CDR;
      S_CDR: return m ? S_E1D : S_SDR;
      S_SDR: return m ? S_E1D : S_SDR;
      S_E1D: return m ? S_UDR : S_PDR;
      S_PDR: return m ? S_E2D : S_PDR;
      S_E2D: return m ? S_UDR : S_SDR;
      S_UDR: return m ? S_SDS : S_RTI;
      S_SIS: return m ? S_TLR : S_CIR;
      S_CIR: return m ? S_E1I : S_SIR;
      S_SIR: return m ? S_E1I : S_SIR;
      S_E1I: return m ? S_UIR : S_PIR;
      S_PIR: return m ? S_E2I : S_PIR;
      S_E2I: return m ? S_UIR : S_SIR;
      default: return m ? S_SDS : S_RTI;
    endcase
  endfunction

  always @(posedge oTck) begin
    case (tapSt)
      S_TLR: ir = IrIdcode;
      S_CDR: if (ir == IrIdcode) idsr = IdCode; else bp = 1'b0;
      S_SDR: if (ir == IrIdcode) idsr = {oTdi, idsr[31:1]}; else bp = oTdi;
      S_CIR: irsr = 4'b0001;
      S_SIR: irsr = {oTdi, irsr[3:1]};
      S_UIR: ir = irsr;
      default: ;
    endcase
    tapSt = tapStep(tapSt, oTms);
  end

  assign iTdo = (tapSt == S_SDR) ? ((ir == IrIdcode) ? idsr[0] : bp) :
                (tapSt == S_SIR) ? irsr[0] : 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic waitReady(output bit to);
    int n = 0;
    while (!oCmdReady && n < 1000) begin
      @(negedge iClk);
      n++;
    end
    to = !oCmdReady;
  endtask

  task automatic runCmd(input logic [1:0] t, input logic [5:0] l, input logic [31:0] d,
                        output logic [31:0] rsp, output int lat, output bit to);
    bit toR;
    waitReady(toR);
    iCmdValid = 1'b1;
    iCmdType  = t;
    iCmdLen   = l;
    iCmdData  = d;
    @(negedge iClk);
    iCmdValid = 1'b0;
    lat = 0;
    while (!oRspValid && lat < 2000) begin
      @(negedge iClk);
      lat++;
    end
    to  = toR || !oRspValid;
    rsp = oRspData;
    iRspReady = 1'b1;
    @(negedge iClk);
    iRspReady = 1'b0;
  endtask

  task automatic releaseAndInit(input string tag);
    int base;
    int n = 0;
    base = tckRises;
    @(negedge iClk);
    iTrst = 1'b1;
    while (!oCmdReady && n < 200) begin
      @(negedge iClk);
      n++;
    end
    check({tag, "_ready"}, 32'(oCmdReady), 32'd1);
    check({tag, "_pulses"}, 32'(tckRises - base), 32'd6);
    check({tag, "_tms"}, tmsHist & 32'h3F, 32'h3E);
    check({tag, "_tap"}, 32'(oTapState), 32'hC);
    check({tag, "_period"}, 32'(period), 32'(2 * CLKDIV));
  endtask

  typedef struct {
    logic [1:0]  t;
    logic [5:0]  len;
    logic [31:0] data;
    logic [31:0] rsp;
    int          pulses;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] rsp, d0;
    int          lat, base, n;
    bit          to, ok;

    vecs[0] = '{2'd1, 6'd4,  32'h0000_0002, 32'h0000_0001, 10};  // IR IDCODE
    vecs[1] = '{2'd0, 6'd32, 32'h0000_0000, IdCode,        37};  // read IDCODE
    vecs[2] = '{2'd1, 6'd4,  32'h0000_0001, 32'h0000_0001, 10};  // IR BYPASS
    vecs[3] = '{2'd0, 6'd8,  32'h0000_00A5, 32'h0000_004A, 13};  // bypass delay
    vecs[4] = '{2'd0, 6'd32, 32'h8000_0001, 32'h0000_0002, 37};  // full-width bypass
    vecs[5] = '{2'd0, 6'd0,  32'hFFFF_FFFF, 32'h0000_0000, 0};   // empty DR scan
    vecs[6] = '{2'd2, 6'd0,  32'h0000_0000, 32'h0000_0000, 6};   // TAP reset
    vecs[7] = '{2'd0, 6'd32, 32'h0000_0000, IdCode,        37};  // IR back at IDCODE
    vecs[8] = '{2'd3, 6'd5,  32'h0000_001F, 32'h0000_0000, 6};   // reserved -> reset
    vecs[9] = '{2'd1, 6'd0,  32'h0000_000F, 32'h0000_0000, 0};   // empty IR scan

    // Reset values
    repeat (3) @(negedge iClk);
    check("rst_tck", 32'(oTck), 32'd0);
    check("rst_tms", 32'(oTms), 32'd1);
    check("rst_tdi", 32'(oTdi), 32'd0);
    check("rst_ready", 32'(oCmdReady), 32'd0);
    check("rst_rspvalid", 32'(oRspValid), 32'd0);
    check("rst_rspdata", oRspData, 32'd0);
    check("rst_tap", 32'(oTapState), 32'hF);

    releaseAndInit("init");

    for (int i = 0; i < 10; i++) begin
      base = tckRises;
      runCmd(vecs[i].t, vecs[i].len, vecs[i].data, rsp, lat, to);
      check($sformatf("v%0d_timeout", i), 32'(to), 32'd0);
      check($sformatf("v%0d_rsp", i), rsp, vecs[i].rsp);
      check($sformatf("v%0d_pulses", i), 32'(tckRises - base), 32'(vecs[i].pulses));
      check($sformatf("v%0d_tap", i), 32'(oTapState), 32'hC);
      if (vecs[i].pulses == 0) check($sformatf("v%0d_latency", i), 32'(lat), 32'd0);
      if (vecs[i].t[1]) check($sformatf("v%0d_tms", i), tmsHist & 32'h3F, 32'h3E);
    end

    // Backpressure with a queued command
    runCmd(2'd1, 6'd4, 32'h1, rsp, lat, to);
    check("bp_ir_timeout", 32'(to), 32'd0);
    waitReady(to);
    iCmdValid = 1'b1; iCmdType = 2'd0; iCmdLen = 6'd8; iCmdData = 32'hA5;
    @(negedge iClk);
    iCmdValid = 1'b0;
    n = 0;
    while (!oRspValid && n < 500) begin @(negedge iClk); n++; end
    d0 = oRspData;
    check("bp_rsp", d0, 32'h4A);
    repeat (4) @(negedge iClk);
    base = tckRises;
    iCmdValid = 1'b1; iCmdType = 2'd0; iCmdLen = 6'd8; iCmdData = 32'h3C;
    ok = 1'b1;
    repeat (20) begin
      @(negedge iClk);
      if (!oRspValid || oRspData !== d0 || oCmdReady || oTck) ok = 1'b0;
    end
    check("bp_stable", 32'(ok), 32'd1);
    check("bp_no_tck", 32'(tckRises - base), 32'd0);
    iRspReady = 1'b1;
    @(negedge iClk);
    iRspReady = 1'b0;
    check("bp_ready_after_take", 32'(oCmdReady), 32'd1);
    check("bp_valid_after_take", 32'(oRspValid), 32'd0);
    @(negedge iClk);
    iCmdValid = 1'b0;
    check("bp_accepted", 32'(oCmdReady), 32'd0);
    n = 0;
    while (!oRspValid && n < 500) begin @(negedge iClk); n++; end
    check("bp_queued_rsp", oRspData, 32'h78);
    iRspReady = 1'b1;
    @(negedge iClk);
    iRspReady = 1'b0;

    // Abort in ShiftDR
    runCmd(2'd1, 6'd4, 32'h2, rsp, lat, to);
    check("ab_ir_rsp", rsp, 32'h1);
    waitReady(to);
    iCmdValid = 1'b1; iCmdType = 2'd0; iCmdLen = 6'd32; iCmdData = 32'h0;
    @(negedge iClk);
    iCmdValid = 1'b0;
    n = 0;
    while (oTapState != 4'h2 && n < 500) begin @(negedge iClk); n++; end
    check("ab_reach_shiftdr", 32'(oTapState), 32'h2);
    iTrst = 1'b0;
    #1;
    check("ab_tck", 32'(oTck), 32'd0);
    check("ab_tms", 32'(oTms), 32'd1);
    check("ab_tap", 32'(oTapState), 32'hF);
    ok = 1'b1;
    repeat (5) begin
      @(negedge iClk);
      if (oRspValid) ok = 1'b0;
    end
    check("ab_no_rsp", 32'(ok), 32'd1);
    releaseAndInit("reinit");
    runCmd(2'd0, 6'd32, 32'h0, rsp, lat, to);
    check("ab_idcode_timeout", 32'(to), 32'd0);
    check("ab_idcode", rsp, IdCode);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
